// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Purpose : Instruction-memory port between the IF stage and the instruction
//           memory. It carries one outstanding request at a time: the request
//           is a level signal and completes on the cycle ImemReady is high.
// Signals : ImemReq   - fetch request (level), driven by the fetch stage
//           ImemAddr  - word address, held stable until ImemReady
//           ImemReady - ImemRData is valid this cycle; completes the request
//           ImemRData - instruction word (architectural bit 0 = vector bit 31)
// Modports: master = fetch stage, slave = instruction memory
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemRData;

  modport master (output ImemReq, output ImemAddr, input ImemReady, input ImemRData);
  modport slave  (input ImemReq, input ImemAddr, output ImemReady, output ImemRData);
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Purpose : IF stage. Holds the PC, fetches over a single-outstanding imem
//           port and presents the fetched word to ID as decoded Next* fields.
//           A one-entry skid buffer absorbs a word that arrives while ID
//           stalls. Redirects from ID squash the wrong path with NOP bubbles.
// Ports   : clk            - rising-edge clock
//           reset          - asynchronous, active-low
//           stall          - ID holding; Next* frozen while high
//           Redirect       - taken jump/branch (ignored while stall is high)
//           RedirectPC     - redirect target
//           imem           - instruction memory port (master side)
//           NextOpCode / NextFunction / NextRs1 / NextRs2 / NextRd / NextImmd
//                          - fields of the presented instruction
//           NextPCPlusFour - address of presented instruction + 4
//           NextValid      - 1 = real instruction, 0 = bubble
// Architectural bit i of a 32-bit word maps to vector bit 31-i (bit 0 = MSB).
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h5400_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 Redirect,
  input  logic [31:0]          RedirectPC,
  instr_fetch_if.master        imem,
  output logic [5:0]           NextOpCode,
  output logic [5:0]           NextFunction,
  output logic [4:0]           NextRs1,
  output logic [4:0]           NextRs2,
  output logic [4:0]           NextRd,
  output logic [15:0]          NextImmd,
  output logic [31:0]          NextPCPlusFour,
  output logic                 NextValid
);

  typedef enum logic [1:0] {S_WAIT, S_FULL, S_DROP} state_t;

  state_t      r_state,     w_state_next;
  logic        r_live,      w_live_next;
  logic [31:0] r_pc,        w_pc_next;
  logic [31:0] r_addr,      w_addr_next;
  logic [31:0] r_out_insn,  w_out_insn_next;
  logic [31:0] r_out_pc4,   w_out_pc4_next;
  logic        r_out_valid, w_out_valid_next;
  logic [31:0] r_skid_insn, w_skid_insn_next;
  logic [31:0] r_skid_pc4,  w_skid_pc4_next;
  logic [31:0] w_pc_plus4;

  // r_live keeps the request low during reset and for the release cycle,
  // so ImemReq=0 while reset is asserted and rises one edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_WAIT;
      r_live      <= 1'b0;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_out_insn  <= NOP_INSN;
      r_out_pc4   <= RESET_PC;
      r_out_valid <= 1'b0;
      r_skid_insn <= NOP_INSN;
      r_skid_pc4  <= RESET_PC;
    end else begin
      r_state     <= w_state_next;
      r_live      <= w_live_next;
      r_pc        <= w_pc_next;
      r_addr      <= w_addr_next;
      r_out_insn  <= w_out_insn_next;
      r_out_pc4   <= w_out_pc4_next;
      r_out_valid <= w_out_valid_next;
      r_skid_insn <= w_skid_insn_next;
      r_skid_pc4  <= w_skid_pc4_next;
    end
  end

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_state_next     = r_state;
    w_live_next      = 1'b1;
    w_pc_next        = r_pc;
    w_addr_next      = r_addr;
    w_out_insn_next  = r_out_insn;
    w_out_pc4_next   = r_out_pc4;
    w_out_valid_next = r_out_valid;
    w_skid_insn_next = r_skid_insn;
    w_skid_pc4_next  = r_skid_pc4;

    if (r_live) begin
      unique case (r_state)
        S_WAIT: begin
          // Remember the address in flight in case a redirect leaves it
          // outstanding; DROP must keep presenting it until acked.
          w_addr_next = r_pc;
          if (Redirect && !stall) begin
            w_pc_next        = RedirectPC;
            w_out_insn_next  = NOP_INSN;
            w_out_valid_next = 1'b0;
            if (!imem.ImemReady) w_state_next = S_DROP;
          end else if (imem.ImemReady) begin
            w_pc_next = w_pc_plus4;
            if (!stall) begin
              w_out_insn_next  = imem.ImemRData;
              w_out_pc4_next   = w_pc_plus4;
              w_out_valid_next = 1'b1;
            end else begin
              w_skid_insn_next = imem.ImemRData;
              w_skid_pc4_next  = w_pc_plus4;
              w_state_next     = S_FULL;
            end
          end else if (!stall) begin
            w_out_insn_next  = NOP_INSN;
            w_out_valid_next = 1'b0;
          end
        end

        S_FULL: begin
          if (!stall) begin
            w_state_next = S_WAIT;
            if (Redirect) begin
              w_pc_next        = RedirectPC;
              w_out_insn_next  = NOP_INSN;
              w_out_valid_next = 1'b0;
            end else begin
              w_out_insn_next  = r_skid_insn;
              w_out_pc4_next   = r_skid_pc4;
              w_out_valid_next = 1'b1;
            end
          end
        end

        S_DROP: begin
          if (!stall) begin
            w_out_insn_next  = NOP_INSN;
            w_out_valid_next = 1'b0;
            if (Redirect) w_pc_next = RedirectPC;
          end
          // Wrong-path response is discarded; the new pc goes out next cycle.
          if (imem.ImemReady) w_state_next = S_WAIT;
        end

        default: w_state_next = S_WAIT;
      endcase
    end
  end

  assign imem.ImemReq  = r_live && (r_state != S_FULL);
  assign imem.ImemAddr = (r_state == S_DROP) ? r_addr : r_pc;

  // Field slices of the output buffer only; no imem-to-output path.
  assign NextOpCode     = r_out_insn[31:26];
  assign NextRs1        = r_out_insn[25:21];
  assign NextRs2        = r_out_insn[20:16];
  assign NextImmd       = r_out_insn[15:0];
  assign NextFunction   = r_out_insn[5:0];
  assign NextPCPlusFour = r_out_pc4;
  assign NextValid      = r_out_valid;

  always_comb begin
    NextRd = r_out_insn[20:16];
    unique case (r_out_insn[31:26])
      6'h00, 6'h01: NextRd = r_out_insn[15:11];
      6'h03, 6'h13: NextRd = 5'd31;  // link register for JAL / JALR-style ops
      default:      NextRd = r_out_insn[20:16];
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Purpose : Directed self-checking bench for instr_fetch. A small imem model
//           with programmable latency answers requests; each test drives
//           stall/Redirect and compares Next* and the imem port against
//           hand-computed values.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [5:0]  NextOpCode;
  logic [5:0]  NextFunction;
  logic [4:0]  NextRs1;
  logic [4:0]  NextRs2;
  logic [4:0]  NextRd;
  logic [15:0] NextImmd;
  logic [31:0] NextPCPlusFour;
  logic        NextValid;

  int n_checks = 0;
  int n_fails  = 0;
  int mem_lat  = 0;
  int mem_cnt  = 0;

  instr_fetch_if imem_bus ();

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_INSN(32'h5400_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .Redirect      (Redirect),
    .RedirectPC    (RedirectPC),
    .imem          (imem_bus.master),
    .NextOpCode    (NextOpCode),
    .NextFunction  (NextFunction),
    .NextRs1       (NextRs1),
    .NextRs2       (NextRs2),
    .NextRd        (NextRd),
    .NextImmd      (NextImmd),
    .NextPCPlusFour(NextPCPlusFour),
    .NextValid     (NextValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_000C: return 32'h2002_0005;
      32'h0000_0300: return 32'h0022_1820;
      32'h0000_0304: return 32'h0C00_0010;
      default:       return a;
    endcase
  endfunction

  // Advance one clock; memory model answers after mem_lat wait cycles.
  task automatic tick();
    logic prev_req, prev_ready;
    prev_req   = imem_bus.ImemReq;
    prev_ready = imem_bus.ImemReady;
    @(posedge clk);
    if (prev_ready)    mem_cnt = 0;
    else if (prev_req) mem_cnt++;
    #1;
    if (!imem_bus.ImemReq) mem_cnt = 0;
    imem_bus.ImemReady = imem_bus.ImemReq && (mem_cnt >= mem_lat);
    imem_bus.ImemRData = imem_bus.ImemReady ? mem_word(imem_bus.ImemAddr) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset(input int lat);
    reset = 1'b0;
    stall = 1'b0;
    Redirect = 1'b0;
    RedirectPC = 32'h0;
    mem_lat = lat;
    mem_cnt = 0;
    imem_bus.ImemReady = 1'b0;
    imem_bus.ImemRData = 32'h0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // ---- Test 1: reset state and zero-wait streaming ----
    do_reset(0);
    chk("rst_req",   {31'd0, imem_bus.ImemReq}, 32'd0);
    chk("rst_addr",  imem_bus.ImemAddr, 32'h0);
    chk("rst_valid", {31'd0, NextValid}, 32'd0);
    chk("rst_op",    {26'd0, NextOpCode}, 32'h15);
    chk("rst_pc4",   NextPCPlusFour, 32'h0);
    tick();
    chk("t1_req",    {31'd0, imem_bus.ImemReq}, 32'd1);
    chk("t1_addr0",  imem_bus.ImemAddr, 32'h0);
    chk("t1_valid0", {31'd0, NextValid}, 32'd0);
    tick();
    chk("t1_valid1", {31'd0, NextValid}, 32'd1);
    chk("t1_imm0",   {16'd0, NextImmd}, 32'h0);
    chk("t1_pc4_0",  NextPCPlusFour, 32'h4);
    chk("t1_addr4",  imem_bus.ImemAddr, 32'h4);
    tick();
    chk("t1_imm4",   {16'd0, NextImmd}, 32'h4);
    chk("t1_pc4_4",  NextPCPlusFour, 32'h8);
    chk("t1_addr8",  imem_bus.ImemAddr, 32'h8);

    // ---- Test 2: stall while 0x2002_0005 arrives ----
    tick();
    chk("t2_addrC",  imem_bus.ImemAddr, 32'hC);
    stall = 1'b1;
    tick();
    chk("t2_req_full", {31'd0, imem_bus.ImemReq}, 32'd0);
    chk("t2_hold_pc4", NextPCPlusFour, 32'hC);
    chk("t2_hold_imm", {16'd0, NextImmd}, 32'h8);
    tick();
    chk("t2_req_full2", {31'd0, imem_bus.ImemReq}, 32'd0);
    chk("t2_hold_pc4b", NextPCPlusFour, 32'hC);
    stall = 1'b0;
    tick();
    chk("t2_op",     {26'd0, NextOpCode}, 32'h08);
    chk("t2_rd",     {27'd0, NextRd}, 32'd2);
    chk("t2_imm",    {16'd0, NextImmd}, 32'h5);
    chk("t2_pc4",    NextPCPlusFour, 32'h10);
    chk("t2_valid",  {31'd0, NextValid}, 32'd1);
    chk("t2_addr10", imem_bus.ImemAddr, 32'h10);
    tick();
    chk("t2_next_imm", {16'd0, NextImmd}, 32'h10);
    chk("t2_next_pc4", NextPCPlusFour, 32'h14);

    // ---- Test 3: redirect while a 3-cycle fetch is outstanding ----
    do_reset(2);
    tick();
    Redirect = 1'b1;
    RedirectPC = 32'h100;
    tick();
    Redirect = 1'b0;
    chk("t3_drop_addr",  imem_bus.ImemAddr, 32'h0);
    chk("t3_drop_req",   {31'd0, imem_bus.ImemReq}, 32'd1);
    chk("t3_bubble",     {31'd0, NextValid}, 32'd0);
    tick();
    tick();
    chk("t3_new_addr",   imem_bus.ImemAddr, 32'h100);
    chk("t3_bubble2",    {31'd0, NextValid}, 32'd0);
    tick();
    tick();
    chk("t3_bubble3",    {31'd0, NextValid}, 32'd0);
    tick();
    chk("t3_valid",      {31'd0, NextValid}, 32'd1);
    chk("t3_pc4",        NextPCPlusFour, 32'h104);
    chk("t3_imm",        {16'd0, NextImmd}, 32'h100);

    // ---- Test 4: redirect in the same cycle as ImemReady ----
    do_reset(0);
    tick();
    Redirect = 1'b1;
    RedirectPC = 32'h200;
    tick();
    Redirect = 1'b0;
    chk("t4_addr",   imem_bus.ImemAddr, 32'h200);
    chk("t4_bubble", {31'd0, NextValid}, 32'd0);
    tick();
    chk("t4_valid",  {31'd0, NextValid}, 32'd1);
    chk("t4_pc4",    NextPCPlusFour, 32'h204);

    // ---- Test 5: field decode and pc wrap ----
    do_reset(0);
    tick();
    Redirect = 1'b1;
    RedirectPC = 32'h300;
    tick();
    Redirect = 1'b0;
    tick();
    chk("t5_r_op",   {26'd0, NextOpCode}, 32'h00);
    chk("t5_r_rs1",  {27'd0, NextRs1}, 32'd1);
    chk("t5_r_rs2",  {27'd0, NextRs2}, 32'd2);
    chk("t5_r_rd",   {27'd0, NextRd}, 32'd3);
    chk("t5_r_fn",   {26'd0, NextFunction}, 32'h20);
    tick();
    chk("t5_j_op",   {26'd0, NextOpCode}, 32'h03);
    chk("t5_j_rd",   {27'd0, NextRd}, 32'd31);
    chk("t5_j_pc4",  NextPCPlusFour, 32'h308);
    Redirect = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    chk("t5_bub_valid", {31'd0, NextValid}, 32'd0);
    chk("t5_bub_pc4",   NextPCPlusFour, 32'h308);
    chk("t5_bub_op",    {26'd0, NextOpCode}, 32'h15);
    chk("t5_bub_rd",    {27'd0, NextRd}, 32'd0);
    chk("t5_top_addr",  imem_bus.ImemAddr, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_pc4",  NextPCPlusFour, 32'h0);
    chk("t5_wrap_addr", imem_bus.ImemAddr, 32'h0);
    chk("t5_wrap_imm",  {16'd0, NextImmd}, 32'hFFFC);

    // ---- Test 6: reset asserted while in DROP ----
    do_reset(2);
    tick();
    tick();
    tick();
    tick();
    chk("t6_valid",     {31'd0, NextValid}, 32'd1);
    chk("t6_pc4",       NextPCPlusFour, 32'h4);
    Redirect = 1'b1;
    RedirectPC = 32'h100;
    tick();
    Redirect = 1'b0;
    chk("t6_drop_addr", imem_bus.ImemAddr, 32'h4);
    reset = 1'b0;
    #1;
    chk("t6_rst_req",   {31'd0, imem_bus.ImemReq}, 32'd0);
    chk("t6_rst_addr",  imem_bus.ImemAddr, 32'h0);
    chk("t6_rst_valid", {31'd0, NextValid}, 32'd0);
    chk("t6_rst_op",    {26'd0, NextOpCode}, 32'h15);
    chk("t6_rst_pc4",   NextPCPlusFour, 32'h0);
    mem_lat = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_resume_req",  {31'd0, imem_bus.ImemReq}, 32'd1);
    chk("t6_resume_addr", imem_bus.ImemAddr, 32'h0);
    tick();
    chk("t6_resume_valid", {31'd0, NextValid}, 32'd1);
    chk("t6_resume_pc4",   NextPCPlusFour, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
